// File: rtl/riscv_mem_arbiter_if.sv
// riscv_mem_arbiter_if: fetch/data requester, BIU and status bundle around the memory arbiter
interface riscv_mem_arbiter_if #(parameter int XLEN = 32);
  logic            if_req, if_flush, if_ack, if_err;
  logic [XLEN-1:0] if_adr, if_q;
  logic            dm_req, dm_we, dm_ack, dm_err;
  logic [XLEN/8-1:0] dm_be;
  logic [XLEN-1:0] dm_adr, dm_d, dm_q;
  logic            biu_req, biu_we, biu_ack, biu_err;
  logic [XLEN/8-1:0] biu_be;
  logic [XLEN-1:0] biu_adr, biu_d, biu_q;
  logic            arb_busy, arb_gnt_dm;
  modport master (
    input  if_req, if_adr, if_flush, dm_req, dm_adr, dm_we, dm_be, dm_d, biu_ack, biu_err, biu_q,
    output if_ack, if_err, if_q, dm_ack, dm_err, dm_q, biu_req, biu_adr, biu_we, biu_be, biu_d,
           arb_busy, arb_gnt_dm
  );
  modport slave (
    output if_req, if_adr, if_flush, dm_req, dm_adr, dm_we, dm_be, dm_d, biu_ack, biu_err, biu_q,
    input  if_ack, if_err, if_q, dm_ack, dm_err, dm_q, biu_req, biu_adr, biu_we, biu_be, biu_d,
           arb_busy, arb_gnt_dm
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one BIU port between fetch and data, data-first with a starvation guard
module riscv_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rstn,
  riscv_mem_arbiter_if.master bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic drop_q, drop_d, gnt_dm_q, gnt_dm_d, req_q, req_d, we_q, we_d;
  logic [XLEN-1:0] adr_q, adr_d, d_q, d_d;
  logic [XLEN/8-1:0] be_q, be_d;
  logic term, gnt_d, gnt_i, drop_now;
  assign term     = bus.biu_ack | bus.biu_err;
  assign gnt_d    = state_q == IDLE && bus.dm_req && !(bus.if_req && starve_q == SW'(STARVE_LIMIT));
  assign gnt_i    = state_q == IDLE && !gnt_d && bus.if_req && !bus.if_flush;
  assign drop_now = drop_q | bus.if_flush;
  assign bus.if_ack     = state_q == GNT_I && term && !drop_now;
  assign bus.if_err     = bus.if_ack & bus.biu_err;
  assign bus.if_q       = bus.if_ack ? bus.biu_q : '0;
  assign bus.dm_ack     = state_q == GNT_D && term;
  assign bus.dm_err     = bus.dm_ack & bus.biu_err;
  assign bus.dm_q       = bus.dm_ack ? bus.biu_q : '0;
  assign bus.biu_req    = req_q;
  assign bus.biu_adr    = adr_q;
  assign bus.biu_we     = we_q;
  assign bus.biu_be     = be_q;
  assign bus.biu_d      = d_q;
  assign bus.arb_busy   = state_q != IDLE;
  assign bus.arb_gnt_dm = gnt_dm_q;
  // Arbitrate in IDLE, latch the winner's command, hold it until the bus terminates the transfer
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    drop_d   = drop_q;
    gnt_dm_d = gnt_dm_q;
    req_d    = req_q;
    adr_d    = adr_q;
    we_d     = we_q;
    be_d     = be_q;
    d_d      = d_q;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (!bus.if_req) starve_d = '0;
        if (gnt_d) begin
          state_d  = GNT_D;
          req_d    = 1'b1;
          adr_d    = bus.dm_adr;
          we_d     = bus.dm_we;
          be_d     = bus.dm_be;
          d_d      = bus.dm_d;
          gnt_dm_d = 1'b1;
          if (bus.if_req) starve_d = starve_q + 1'b1;
        end else if (gnt_i) begin
          state_d  = GNT_I;
          req_d    = 1'b1;
          adr_d    = bus.if_adr;
          we_d     = 1'b0;
          be_d     = '1;
          d_d      = '0;
          gnt_dm_d = 1'b0;
          starve_d = '0;
        end
      end
      default: begin
        if (term) begin
          state_d = IDLE;
          req_d   = 1'b0;
          drop_d  = 1'b0;
        end else if (state_q == GNT_I) drop_d = drop_now;
      end
    endcase
  end
  // State and command registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      starve_q <= '0;
      drop_q   <= 1'b0;
      gnt_dm_q <= 1'b0;
      req_q    <= 1'b0;
      adr_q    <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      d_q      <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
      gnt_dm_q <= gnt_dm_d;
      req_q    <= req_d;
      adr_q    <= adr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      d_q      <= d_d;
    end
  end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed scenarios plus random traffic against a transaction-level model
module tb_riscv_mem_arbiter;
  localparam int XLEN = 32;
  localparam int LIM  = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  riscv_mem_arbiter_if #(.XLEN(XLEN)) bus();
  riscv_mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;
  // model: the transfer currently owning the bus, and fetch's waiting history
  bit cur_v, cur_drop, last_dm;
  int cur_who;
  int waits;
  logic [XLEN-1:0] cur_adr, cur_d;
  logic cur_we;
  logic [3:0] cur_be;
  logic dlog[$];
  logic prev_req, seen_if_ack, seen_dm_ack;
  logic term, e_ia, e_da;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_req();
    for (int i = 0; i < 20 && bus.biu_req !== 1'b1; i++) cyc(1);
    chk("wait_biu_req", bus.biu_req, 1);
  endtask
  task automatic model_reset();
    cur_v = 0; cur_drop = 0; last_dm = 0; cur_who = 0; waits = 0;
  endtask
  // compare every cycle against the model, then advance the model by one clock
  always @(negedge clk) begin
    if (chk_en) begin
      term = cur_v && (bus.biu_ack || bus.biu_err);
      e_ia = term && cur_who == 1 && !cur_drop && !bus.if_flush;
      e_da = term && cur_who == 2;
      chk("biu_req", bus.biu_req, cur_v);
      chk("arb_busy", bus.arb_busy, cur_v);
      chk("arb_gnt_dm", bus.arb_gnt_dm, last_dm);
      if (cur_v) begin
        chk("biu_adr", bus.biu_adr, cur_adr);
        chk("biu_we", bus.biu_we, cur_we);
        chk("biu_be", bus.biu_be, cur_be);
        chk("biu_d", bus.biu_d, cur_d);
      end
      chk("if_ack", bus.if_ack, e_ia);
      chk("if_err", bus.if_err, e_ia && bus.biu_err);
      chk("if_q", bus.if_q, e_ia ? bus.biu_q : 0);
      chk("dm_ack", bus.dm_ack, e_da);
      chk("dm_err", bus.dm_err, e_da && bus.biu_err);
      chk("dm_q", bus.dm_q, e_da ? bus.biu_q : 0);
      if (bus.biu_req && !prev_req) dlog.push_back(bus.arb_gnt_dm);
      prev_req = bus.biu_req;
      seen_if_ack = bus.if_ack;
      seen_dm_ack = bus.dm_ack;
      if (!rstn) model_reset();
      else if (cur_v) begin
        if (cur_who == 1 && bus.if_flush) cur_drop = 1;
        if (term) begin cur_v = 0; cur_drop = 0; end
      end else if (bus.dm_req && !(bus.if_req && waits == LIM)) begin
        cur_v = 1; cur_who = 2; last_dm = 1;
        cur_adr = bus.dm_adr; cur_we = bus.dm_we; cur_be = bus.dm_be; cur_d = bus.dm_d;
        waits = bus.if_req ? (waits < LIM ? waits + 1 : LIM) : 0;
      end else if (!bus.if_req) waits = 0;
      else if (!bus.if_flush) begin
        cur_v = 1; cur_who = 1; last_dm = 0; waits = 0;
        cur_adr = bus.if_adr; cur_we = 0; cur_be = 4'hF; cur_d = 0;
      end
    end
  end
  initial begin
    logic exp_seq [10];
    bit prev_flush;
    exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    {bus.if_req, bus.if_flush, bus.dm_req, bus.dm_we, bus.biu_ack, bus.biu_err} = '0;
    bus.if_adr = '0; bus.dm_adr = '0; bus.dm_be = '0; bus.dm_d = '0; bus.biu_q = '0;
    model_reset();
    prev_req = 0;
    @(posedge clk);
    chk_en = 1;
    cyc(1);
    chk("rst_biu_req", bus.biu_req, 0);
    chk("rst_biu_adr", bus.biu_adr, 0);
    chk("rst_biu_be", bus.biu_be, 0);
    chk("rst_busy", bus.arb_busy, 0);
    rstn = 1;
    // single fetch
    bus.if_req = 1; bus.if_adr = 32'h200;
    wait_req();
    cyc(2);
    bus.biu_ack = 1; bus.biu_q = 32'h13;
    #1;
    chk("fetch_ack", bus.if_ack, 1);
    chk("fetch_q", bus.if_q, 32'h13);
    chk("fetch_dm_ack", bus.dm_ack, 0);
    chk("fetch_we", bus.biu_we, 0);
    chk("fetch_be", bus.biu_be, 4'hF);
    cyc(1);
    bus.biu_ack = 0; bus.if_req = 0;
    cyc(2);
    // contention: data first, then fetch
    bus.if_req = 1; bus.if_adr = 32'h300;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_adr = 32'h1000; bus.dm_be = 4'h3; bus.dm_d = 32'hDEADBEEF;
    wait_req();
    chk("cont_gnt_dm", bus.arb_gnt_dm, 1);
    chk("cont_adr", bus.biu_adr, 32'h1000);
    chk("cont_we", bus.biu_we, 1);
    chk("cont_be", bus.biu_be, 4'h3);
    chk("cont_d", bus.biu_d, 32'hDEADBEEF);
    bus.biu_ack = 1;
    #1;
    chk("cont_dm_ack", bus.dm_ack, 1);
    cyc(1);
    bus.biu_ack = 0; bus.dm_req = 0;
    cyc(1);
    wait_req();
    chk("cont_gnt_if", bus.arb_gnt_dm, 0);
    chk("cont_if_adr", bus.biu_adr, 32'h300);
    bus.biu_ack = 1;
    cyc(1);
    bus.biu_ack = 0; bus.if_req = 0;
    cyc(2);
    // starvation: both held, zero-latency bus
    dlog.delete();
    bus.if_req = 1; bus.dm_req = 1; bus.dm_we = 0;
    for (int i = 0; i < 26; i++) begin
      bus.biu_ack = bus.biu_req;
      cyc(1);
    end
    bus.if_req = 0; bus.dm_req = 0;
    for (int i = 0; i < 3; i++) begin
      bus.biu_ack = bus.biu_req;
      cyc(1);
    end
    bus.biu_ack = 0;
    for (int i = 0; i < 10; i++) chk("starve_seq", i < dlog.size() ? dlog[i] : 1'bx, exp_seq[i]);
    cyc(2);
    // flush mid fetch
    bus.if_req = 1; bus.if_adr = 32'h400;
    wait_req();
    cyc(1);
    bus.if_flush = 1; bus.if_req = 0;
    cyc(1);
    bus.if_flush = 0; bus.biu_ack = 1; bus.biu_q = 32'h77;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_adr = 32'h2000;
    #1;
    chk("flush_if_ack", bus.if_ack, 0);
    chk("flush_if_err", bus.if_err, 0);
    cyc(1);
    bus.biu_ack = 0;
    wait_req();
    chk("flush_dm_gnt", bus.arb_gnt_dm, 1);
    bus.biu_ack = 1; bus.biu_q = 32'h55;
    #1;
    chk("flush_dm_ack", bus.dm_ack, 1);
    chk("flush_dm_q", bus.dm_q, 32'h55);
    cyc(1);
    bus.biu_ack = 0; bus.dm_req = 0;
    cyc(2);
    // bus error on data read
    bus.dm_req = 1; bus.dm_adr = 32'h3000;
    wait_req();
    cyc(1);
    bus.biu_err = 1;
    #1;
    chk("err_dm_ack", bus.dm_ack, 1);
    chk("err_dm_err", bus.dm_err, 1);
    chk("err_if_ack", bus.if_ack, 0);
    cyc(1);
    bus.biu_err = 0; bus.dm_req = 0;
    chk("err_idle", bus.arb_busy, 0);
    cyc(2);
    // reset mid data transfer
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_adr = 32'h4000;
    wait_req();
    cyc(1);
    rstn = 0;
    cyc(1);
    chk("rst_mid_req", bus.biu_req, 0);
    chk("rst_mid_busy", bus.arb_busy, 0);
    chk("rst_mid_dm_ack", bus.dm_ack, 0);
    chk("rst_mid_if_ack", bus.if_ack, 0);
    chk("rst_mid_gnt_dm", bus.arb_gnt_dm, 0);
    rstn = 1; bus.dm_req = 0; bus.if_req = 1; bus.if_adr = 32'h500;
    wait_req();
    chk("rst_after_gnt", bus.arb_gnt_dm, 0);
    chk("rst_after_adr", bus.biu_adr, 32'h500);
    bus.biu_ack = 1;
    #1;
    chk("rst_after_ack", bus.if_ack, 1);
    cyc(1);
    bus.biu_ack = 0; bus.if_req = 0;
    cyc(2);
    // random traffic
    prev_flush = 0;
    for (int i = 0; i < 4000; i++) begin
      if (!bus.if_req || seen_if_ack || prev_flush) begin
        bus.if_req = ($urandom % 3) != 0;
        bus.if_adr = $urandom & 32'hFFFF_FFFC;
      end
      bus.if_flush = ($urandom % 12) == 0;
      prev_flush = bus.if_flush;
      if (!bus.dm_req || seen_dm_ack) begin
        bus.dm_req = $urandom % 2;
        bus.dm_adr = $urandom; bus.dm_we = $urandom % 2;
        bus.dm_be = 4'($urandom); bus.dm_d = $urandom;
      end
      bus.biu_ack = bus.biu_req ? ($urandom % 3) == 0 : ($urandom % 8) == 0;
      bus.biu_err = ($urandom % 6) == 0;
      bus.biu_q = $urandom;
      rstn = ($urandom % 250) != 0;
      cyc(1);
    end
    {bus.if_req, bus.if_flush, bus.dm_req, bus.biu_ack, bus.biu_err} = '0;
    rstn = 1;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Shares the single external bus interface unit (BIU) port between the instruction-fetch requester and the data-memory requester of the RISC-V core. One transaction is in flight at a time. Data accesses have fixed priority, with a starvation counter that forces an instruction grant after a configurable number of consecutive data grants. An instruction-flush input discards the response of an in-flight fetch so the fetch unit never sees a stale parcel.

## Interface
- XLEN, 32, address/data width
- STARVE_LIMIT, 4, consecutive data grants, taken while if_req is pending, after which the next grant goes to fetch; must be ≥1
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- if_req  in  1  fetch request; held with if_adr stable until if_ack
- if_adr  in  XLEN  fetch address
- if_flush  in  1  discard current/pending fetch
- if_ack  out  1  fetch complete (1-cycle pulse)
- if_err  out  1  fetch bus error; valid with if_ack
- if_q  out  XLEN  fetch read data; valid with if_ack
- dm_req  in  1  data request; held with command stable until dm_ack
- dm_adr  in  XLEN  data address
- dm_we  in  1  write enable
- dm_be  in  XLEN/8  byte enables
- dm_d  in  XLEN  write data
- dm_ack  out  1  data complete (1-cycle pulse)
- dm_err  out  1  data bus error; valid with dm_ack
- dm_q  out  XLEN  read data; valid with dm_ack
- biu_req  out  1  bus request
- biu_adr  out  XLEN  bus address
- biu_we  out  1  bus write enable
- biu_be  out  XLEN/8  bus byte enables
- biu_d  out  XLEN  bus write data
- biu_ack  in  1  bus transfer done
- biu_err  in  1  bus error, terminates the transfer like biu_ack
- biu_q  in  XLEN  bus read data
- arb_busy  out  1  state ≠ IDLE
- arb_gnt_dm  out  1  current/last grant was to data

## Operation
- States: IDLE, GNT_I, GNT_D.
- IDLE arbitration, evaluated each cycle:
  - if dm_req and not (if_req and starve_cnt==STARVE_LIMIT) → GNT_D;
  - else if if_req and not if_flush → GNT_I;
  - else stay IDLE.
- On a grant, register the winner's command into the biu_* outputs (fetch: biu_we=0, biu_be=all ones, biu_d=0) and set biu_req=1.
- starve_cnt:
  - +1 on a data grant while if_req=1, saturating at STARVE_LIMIT;
  - cleared on a fetch grant;
  - cleared in IDLE when if_req=0.
- GNT_x: biu_req and the command are held until a cycle with biu_ack or biu_err (the termination cycle).
  - Termination cycle: the granted requester's ack=1, err=biu_err, q=biu_q, all routed combinationally.
  - Next state IDLE, biu_req=0.
- Flush handling:
  - if_flush in GNT_I sets drop flag; drop flag also set if if_flush coincides with the termination cycle.
  - With drop set, termination produces no if_ack/if_err; drop is cleared on return to IDLE.
  - if_flush in IDLE blocks a fetch grant that cycle only.
- The non-granted requester's ack/err stay 0. if_q/dm_q are don't-care when their ack=0; they are driven 0 for determinism.
- biu_ack/biu_err in IDLE are ignored (no requester ack).

## Timing
- Reset (rstn=0 at a clk edge):
  - state=IDLE, biu_req=0, biu_adr/biu_d/biu_be=0, biu_we=0;
  - starve_cnt=0, drop=0, arb_gnt_dm=0;
  - if_ack=dm_ack=if_err=dm_err=0, arb_busy=0.
- Reset mid-transaction abandons the transfer; the BIU is reset together with the core.
- Request seen in IDLE at cycle N → biu_req=1 from N+1.
- biu_ack at cycle M (M ≥ N+1) → requester ack at M, biu_req=0 and IDLE at M+1.
- Earliest next biu_req is M+2; back-to-back throughput is one transfer per (bus latency + 2) cycles.
- Requesters must update or deassert req on the clock edge that samples their ack, so no duplicate grant occurs.
- Simultaneous if_req and dm_req in IDLE go to data unless starve_cnt==STARVE_LIMIT.
- biu_ack and biu_err together are treated as an error termination.

## Test plan
- Single fetch: if_req, if_adr=0x200, biu_ack 2 cycles after biu_req, biu_q=0x00000013 → if_ack pulse with if_q=0x13, dm_ack=0, biu_we=0, biu_be=4'hF.
- Contention: if_req and dm_req both high (dm_we=1, dm_adr=0x1000, dm_be=4'h3, dm_d=0xDEADBEEF) → data granted first with biu_* matching; fetch granted after IDLE.
- Starvation with STARVE_LIMIT=4, dm_req and if_req held continuously → grant sequence D,D,D,D,I,D,… ; starve_cnt resets after the I grant.
- Flush: if_flush pulsed mid GNT_I, then biu_ack → no if_ack/if_err; the following dm_req is served normally.
- Error: biu_err=1 on a data read → dm_ack=1, dm_err=1, if_ack=0; state IDLE next cycle.
- Reset mid-transfer: rstn=0 while in GNT_D → next cycle biu_req=0, arb_busy=0, all acks 0; a subsequent if_req is granted normally.
